// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types, constants and parity helper for the parity link
package parity_pkg;

  localparam int MAX_DATA_W = 16;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Zero-extended words give the same result, so narrower payloads can share this.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                       input logic odd_sel);
    return (^data) ^ odd_sel;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - bit-period down-counter; tick marks the last cycle of each period
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/parity_serial_tx.sv
// rtl/parity_serial_tx.sv - UART-style framer: start, data LSB-first, parity, stop
module parity_serial_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              odd_sel,
  output logic              tx_out,
  output logic              busy,
  output logic              tx_done,
  output logic              par_out
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              par_q, par_d;
  logic              accept;
  logic              timer_en;
  logic              tick;

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign timer_en = (state_q != IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .en  (timer_en),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (tick) state_d = DATA;
      DATA:    if (tick && (bit_q == LAST_BIT)) state_d = PARITY;
      PARITY:  if (tick) state_d = STOP;
      STOP:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The word and its parity are captured at the handshake, so upstream may change mid-frame.
  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    if (accept) begin
      shift_d = in_data;
      bit_d   = '0;
      par_d   = calc_parity(MAX_DATA_W'(in_data), odd_sel);
    end else if ((state_q == DATA) && tick) begin
      shift_d = shift_q >> 1;
      bit_d   = (bit_q == LAST_BIT) ? '0 : bit_q + 1'b1;
    end
  end

  always_comb begin
    tx_out = 1'b1;
    unique case (state_q)
      START:   tx_out = 1'b0;
      DATA:    tx_out = shift_q[0];
      PARITY:  tx_out = par_q;
      default: tx_out = 1'b1;
    endcase
    busy    = (state_q != IDLE);
    tx_done = (state_q == STOP) && tick;
    par_out = par_q;
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// tb/tb_parity_serial_tx.sv - scoreboard bench for parity_serial_tx
module tb_parity_serial_tx;

  localparam int DW   = 4;
  localparam int CPB  = 4;
  localparam int NCYC = (DW + 3) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          odd_sel = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, tx_out, busy, tx_done, par_out;

  parity_serial_tx #(
    .DATA_W(DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .odd_sel (odd_sel),
    .tx_out  (tx_out),
    .busy    (busy),
    .tx_done (tx_done),
    .par_out (par_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  bit mon_en = 0;
  bit mon_busy = 0;
  bit prev_busy = 0;
  int last_done = -100;

  typedef struct {
    logic [DW-1:0] data;
    logic          odd;
    int            abort;
    bit            b2b;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic model_par(input logic [DW-1:0] d, input logic odd);
    return logic'($countones(d) % 2) ^ odd;
  endfunction

  // Frame slot b: 0 start, 1..DW data LSB first, DW+1 parity, DW+2 stop.
  function automatic logic exp_bit(input exp_t e, input int b, input logic p);
    if (b == 0) return 1'b0;
    if (b <= DW) return e.data[b-1];
    if (b == DW + 1) return p;
    return 1'b1;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic odd, input bit keep,
                      input bit b2b, input int abort);
    exp_t e;
    bit   ok;
    ok = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    odd_sel  = odd;
    for (int i = 0; i < 500; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e.data  = d;
    e.odd   = odd;
    e.abort = abort;
    e.b2b   = b2b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = keep;
    in_data  = DW'($urandom);
    odd_sel  = 1'($urandom);
    if (abort > 0) begin
      repeat (abort - 1) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
    end
  endtask

  initial begin : monitor
    exp_t          e;
    logic          p;
    logic [DW+2:0] rx;
    int            lim;
    int            b;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy && !prev_busy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            e = exp_q.pop_front();
            mon_busy = 1;
            p = model_par(e.data, e.odd);
            if (e.b2b) chk("b2b_gap", cyc - last_done, 2);
            lim = (e.abort > 0) ? e.abort + 1 : NCYC + 1;
            rx = '0;
            for (int k = 1; k <= lim; k++) begin
              if (k > 1) @(negedge clk);
              if (k == lim) begin
                chk((e.abort > 0) ? "abort_busy" : "frame_len_busy", busy, 0);
                chk((e.abort > 0) ? "abort_tx" : "frame_end_tx", tx_out, 1);
                chk((e.abort > 0) ? "abort_done" : "frame_end_done", tx_done, 0);
              end else begin
                b = (k - 1) / CPB;
                chk("tx_bit", tx_out, exp_bit(e, b, p));
                chk("busy", busy, 1);
                chk("tx_done", tx_done, (k == NCYC) ? 1 : 0);
                chk("par_out", par_out, p);
                if ((k - 1) % CPB == CPB / 2) rx[b] = tx_out;
                if (k == NCYC) last_done = cyc;
              end
            end
            if (e.abort == 0) begin
              chk("loop_data", rx[DW:1], e.data);
              chk("loop_parity_ok", ($countones(rx[DW+1:1]) % 2), e.odd);
            end
            mon_busy = 0;
          end
        end else if (!busy) begin
          chk("idle_tx", tx_out, 1);
          chk("idle_done", tx_done, 0);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin : watchdog
    #(100000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    bit prev_keep;
    bit keep;
    int abort;
    bit drained;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_par", par_out, 0);
    chk("rst_ready", in_ready, 1);
    mon_en = 1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_ready", in_ready, 1);
    end

    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 4'b1001;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_wins_busy", busy, 0);
    chk("rst_wins_tx", tx_out, 1);

    send(4'b0011, 1'b0, 0, 0, 0);
    send(4'b0001, 1'b0, 0, 0, 0);
    send(4'b0001, 1'b1, 0, 0, 0);
    send(4'b0111, 1'b1, 0, 0, 0);
    send(4'b1010, 1'b0, 1, 0, 0);
    send(4'b1111, 1'b0, 0, 1, 0);
    send(4'b1101, 1'b0, 0, 0, 2 * CPB + 2);
    send(4'b0110, 1'b1, 0, 0, 0);

    prev_keep = 0;
    for (int i = 0; i < 40; i++) begin
      keep = (i < 39) ? 1'($urandom) : 1'b0;
      abort = (!keep && ($urandom % 6 == 0)) ? int'($urandom_range(CPB + 1, CPB * (DW + 1))) : 0;
      send(DW'($urandom), 1'($urandom), keep, prev_keep, abort);
      prev_keep = keep;
      if (!keep) repeat ($urandom % 3) @(posedge clk);
    end

    drained = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy && !busy) begin
        drained = 1;
        break;
      end
    end
    chk("drain", drained, 1);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
